// File: rtl/flag_unit.sv
// Architectural condition-flag register with per-flag ALU update mask and a
// small LIFO save/restore stack. Flag encoding: bit0 carry, bit1 zero, bit2 sign.
module flag_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_carry,
    input  logic [2:0]               flag_we,
    input  logic                     push,
    input  logic                     pop,
    output logic [2:0]               flag,
    output logic [2:0]               flag_fwd,
    output logic [$clog2(DEPTH):0]   stack_count,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     stack_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [2:0]    flag_r;
    logic [CW-1:0] count_r;
    logic          err_r;
    logic [2:0]    stack_mem_r [DEPTH];

    logic [2:0]    alu_flag_s;
    logic [2:0]    upd_flag_s;
    logic [2:0]    next_flag_s;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic          fault_s;
    logic [IW-1:0] wr_idx_s;
    logic [IW-1:0] top_idx_s;

    // Stack status and legality of the requested stack operation.
    always_comb begin
        full_s    = (count_r == FULL_CNT);
        empty_s   = (count_r == {CW{1'b0}});
        push_ok_s = push & ~pop & ~full_s;
        pop_ok_s  = pop & ~push & ~empty_s;
        // A lone push into a full stack or a lone pop from an empty one is a fault.
        fault_s   = (push & ~pop & full_s) | (pop & ~push & empty_s);
        wr_idx_s  = count_r[IW-1:0];
        top_idx_s = IW'(count_r - CW'(1));
    end

    // Next flag value: a legal pop restores the saved word, otherwise the masked ALU update.
    always_comb begin
        alu_flag_s  = {alu_result[WIDTH-1], (alu_result == {WIDTH{1'b0}}), alu_carry};
        upd_flag_s  = (flag_we & alu_flag_s) | (~flag_we & flag_r);
        next_flag_s = upd_flag_s;
        if (pop_ok_s) begin
            next_flag_s = stack_mem_r[top_idx_s];
        end else begin
            next_flag_s = upd_flag_s;
        end
    end

    // Flag, stack depth and sticky error state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flag_r  <= 3'b000;
            count_r <= {CW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            flag_r <= next_flag_s;
            if (push_ok_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_ok_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
            if (fault_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Stack storage; never reset because an empty stack is never read.
    always_ff @(posedge clk) begin
        if (rst && push_ok_s) begin
            stack_mem_r[wr_idx_s] <= flag_r;
        end
    end

    assign flag        = flag_r;
    assign flag_fwd    = next_flag_s;
    assign stack_count = count_r;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign stack_err   = err_r;

endmodule

// File: tb/tb_flag_unit.sv
// Randomized and directed checking of flag_unit against a queue-based reference model.
module tb_flag_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic        alu_carry = 1'b0;
    logic [2:0]  flag_we = 3'b000;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [2:0]  flag;
    logic [2:0]  flag_fwd;
    logic [2:0]  stack_count;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] flag_m = 3'b000;
    logic       err_m = 1'b0;
    logic [2:0] q_m [$];

    flag_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .alu_carry(alu_carry),
        .flag_we(flag_we), .push(push), .pop(pop), .flag(flag), .flag_fwd(flag_fwd),
        .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        check_val("flag", {29'd0, flag}, {29'd0, flag_m});
        check_val("stack_count", {29'd0, stack_count}, q_m.size());
        check_val("stack_full", {31'd0, stack_full}, {31'd0, (q_m.size() == DEPTH)});
        check_val("stack_empty", {31'd0, stack_empty}, {31'd0, (q_m.size() == 0)});
        check_val("stack_err", {31'd0, stack_err}, {31'd0, err_m});
    endtask

    // One clock: drive inputs, check current state and forward value, then advance the model.
    task automatic step(input logic r, input logic pu, input logic po, input logic [2:0] we,
                        input logic [31:0] res, input logic cy);
        logic [2:0] newf;
        logic [2:0] nf;
        int sz;
        @(negedge clk);
        rst = r; push = pu; pop = po; flag_we = we; alu_result = res; alu_carry = cy;
        #1;
        check_state();
        newf = {res[31], (res == 32'd0), cy};
        sz = q_m.size();
        nf = flag_m;
        if (po && !pu && sz > 0) begin
            nf = q_m[sz-1];
        end else begin
            for (int i = 0; i < 3; i++) if (we[i]) nf[i] = newf[i];
        end
        check_val("flag_fwd", {29'd0, flag_fwd}, {29'd0, nf});
        @(posedge clk);
        if (!r) begin
            flag_m = 3'b000;
            err_m = 1'b0;
            q_m.delete();
        end else begin
            if (pu && !po) begin
                if (sz == DEPTH) err_m = 1'b1;
                else q_m.push_back(flag_m);
            end
            if (po && !pu) begin
                if (sz == 0) err_m = 1'b1;
                else void'(q_m.pop_back());
            end
            flag_m = nf;
        end
    endtask

    task automatic expect_flag(input string tag, input logic [2:0] exp);
        #2;
        check_val(tag, {29'd0, flag}, {29'd0, exp});
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        // Reset then idle
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 3'b000, $urandom, 1'b1);
        expect_flag("idle_000", 3'b000);

        // Masked update
        step(1'b1, 1'b0, 1'b0, 3'b111, 32'd0, 1'b1);
        expect_flag("masked_011", 3'b011);
        step(1'b1, 1'b0, 1'b0, 3'b100, 32'h8000_0001, 1'b0);
        expect_flag("masked_111", 3'b111);

        // Push/pop restore
        step(1'b1, 1'b0, 1'b0, 3'b111, 32'h8000_0001, 1'b1);
        expect_flag("set_101", 3'b101);
        step(1'b1, 1'b1, 1'b0, 3'b111, 32'd5, 1'b0);
        expect_flag("push_000", 3'b000);
        step(1'b1, 1'b0, 1'b1, 3'b111, 32'd0, 1'b1);
        expect_flag("pop_101", 3'b101);

        // Overflow with distinct saved values, then drain
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 3'b111, (i % 2) ? 32'd0 : 32'h8000_0000 + i, i[0]);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 3'b111, $urandom, 1'b1);

        // Underflow while empty with zero-flag write
        step(1'b1, 1'b0, 1'b0, 3'b111, 32'd1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'b010, 32'd0, 1'b0);
        expect_flag("underflow_010", 3'b010);

        // Simultaneous push+pop after reset at count 2
        step(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'b111, 32'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 3'b111, 32'h8000_0000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3'b001, 32'd7, 1'b1);
        step(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 1'b0);

        // Reset mid-operation
        step(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 3'b111, $urandom, i[0]);
        step(1'b1, 1'b0, 1'b0, 3'b111, 32'h8000_0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'b010, 32'd0, 1'b0);
        expect_flag("mid_110", 3'b110);
        step(1'b0, 1'b1, 1'b0, 3'b111, 32'd0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 3'b000, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] res;
            logic r;
            res = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            r = ($urandom_range(0, 59) != 0);
            step(r, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                 3'($urandom), res, 1'($urandom));
        end

        @(negedge clk);
        #1;
        check_state();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Produces and holds the architectural condition flags that the branch-condition logic consumes; bit encoding is flag = [0-carry, 1-zero, 2-sign].
- Derives carry/zero/sign from the ALU result and latches them per-flag under an update mask.
- Provides a small LIFO flag save/restore stack for interrupt/call entry and return.
- Sits between the ALU output stage and the branch-condition block; `flag` feeds that block directly.

Parameters:
- WIDTH, 32, ALU result width in bits.
- DEPTH, 4, flag stack entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- alu_result  input  WIDTH  ALU result of the instruction in writeback.
- alu_carry  input  1  ALU carry-out of the same instruction.
- flag_we  input  3  per-flag write enable: bit0 carry, bit1 zero, bit2 sign.
- push  input  1  save current flag onto stack this cycle.
- pop  input  1  restore flag from stack top this cycle.
- flag  output  3  registered flags [0-carry, 1-zero, 2-sign].
- flag_fwd  output  3  combinational: value flag will hold after the next edge (bypass for same-cycle branch resolution).
- stack_count  output  $clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
- stack_full  output  1  stack_count == DEPTH.
- stack_empty  output  1  stack_count == 0.
- stack_err  output  1  sticky: any overflow or underflow since reset.

Behaviour:
- Reset (rst low at an edge): flag=3'b000, stack_count=0, stack_err=0. Stack storage is not reset; it is never read while empty. Reset wins over every other input in that cycle.
- Derived values:
  - new_c = alu_carry
  - new_z = (alu_result == 0)
  - new_s = alu_result[WIDTH-1]
- Flag update with no valid pop: flag[i] <= new_i where flag_we[i]=1, otherwise flag[i] holds. Latency is one cycle.
- Valid push (push=1, pop=0, not full):
  - Store the pre-edge `flag` value (before this cycle's flag_we update) at stack[stack_count].
  - stack_count increments.
  - flag_we still updates flag in the same cycle.
- Valid pop (pop=1, push=0, not empty):
  - flag <= stack[stack_count-1] and stack_count decrements.
  - Pop overrides flag_we entirely; no flag bit is written from the ALU that cycle.
- push=1 and pop=1 together: no stack operation, stack_count unchanged, stack_err unchanged; flag_we applies normally.
- Overflow (push alone while full): push ignored, count unchanged, stack_err <= 1; flag_we applies.
- Underflow (pop alone while empty): pop ignored, stack_err <= 1; flag_we applies as if pop were absent.
- stack_err clears only on reset.
- flag_fwd equals the value flag takes at the next edge under all of the rules above, excluding reset.
  - Pure function of current state and inputs; no combinational path from rst.
- stack_full, stack_empty and stack_count are registered-state derived; they change only after an edge.
- Wrap-around: none. The count saturates logically at 0 and DEPTH via the overflow/underflow rules and never wraps.

Test Plan:
- Reset then idle: flag=000, stack_count=0, stack_empty=1, stack_full=0, stack_err=0; hold for 5 cycles with all enables low -> outputs unchanged.
- Masked update: alu_result=0, alu_carry=1, flag_we=111 -> flag=011 next cycle. Then alu_result=32'h8000_0001, alu_carry=0, flag_we=100 -> flag=111 (only sign written, to 1). flag_fwd matches each new value one cycle early.
- Push/pop restore:
  - With flag=101, push with flag_we=111, alu_result=5, carry=0 -> stack_count=1, flag=000.
  - Then pop with flag_we=111 -> flag=101, stack_count=0; the ALU inputs are ignored.
- Overflow: 4 pushes fill the stack (stack_full=1) -> 5th push leaves stack_count=4 and sets stack_err=1. Then 4 pops return the saved values in reverse order; stack_err stays 1.
- Underflow and simultaneous ops:
  - Pop while empty with flag_we=010, alu_result=0 -> flag[1]=1, stack_err=1, count=0.
  - After reset, push+pop together at count=2 -> count stays 2, stack_err stays 0.
- Reset mid-operation: after 3 pushes and flag=110, assert rst low for one edge while push=1 -> flag=000, stack_count=0, stack_err=0. The next pop underflows and sets stack_err.
